// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit teaching CPU: default widths, opcode and FSM
// state encodings, and the opcode-to-control-strobe decoder.
package cpu4_pkg;

  localparam int CPU4_ADDR_W = 4;
  localparam int CPU4_DATA_W = 8;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD_IR = 3'd2,
    ST_EXEC    = 3'd3,
    ST_HALTED  = 3'd4
  } state_e;

  typedef struct packed {
    logic acc_ld;
    logic alu_en;
    logic alu_sub;
    logic out_ld;
  } ctrl_t;

  // Unlisted opcodes fall through to all-zero strobes and behave as NOP.
  function automatic ctrl_t decode_op(input logic [3:0] opc);
    ctrl_t c;
    c = '0;
    case (opc)
      OP_LDA: c.acc_ld = 1'b1;
      OP_ADD: begin
        c.acc_ld = 1'b1;
        c.alu_en = 1'b1;
      end
      OP_SUB: begin
        c.acc_ld  = 1'b1;
        c.alu_en  = 1'b1;
        c.alu_sub = 1'b1;
      end
      OP_OUT:  c.out_ld = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: 2^ADDR_W words, registered read port and synchronous write port.
// Contents are deliberately left without reset so a program survives rst_n.
module prog_mem
  import cpu4_pkg::*;
#(
  parameter int ADDR_W = CPU4_ADDR_W,
  parameter int DATA_W = CPU4_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: on each cp rising edge fetches mem[pc], loads the
// instruction register and pulses one cycle of decoded control strobes.
module instr_fetch_decode
  import cpu4_pkg::*;
#(
  parameter int ADDR_W = CPU4_ADDR_W,
  parameter int DATA_W = CPU4_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              cp,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] operand,
  output logic              op_valid,
  output logic              acc_ld,
  output logic              alu_en,
  output logic              alu_sub,
  output logic              out_ld,
  output logic              busy,
  output logic              halted,
  output logic              overrun
);

  state_e            state;
  logic              cp_q;
  logic              armed;
  logic              pending;
  logic              req;
  logic              mem_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        rd_opc;
  logic [3:0]        ir_opc;

  // armed stays low until cp is seen low after reset, so a cp held high through
  // reset release does not count as a rising edge.
  assign req     = cp & ~cp_q & armed;
  assign busy    = (state == ST_FETCH) || (state == ST_LOAD_IR) || (state == ST_EXEC);
  assign halted  = (state == ST_HALTED);
  assign mem_we  = prog_we & ((state == ST_IDLE) || (state == ST_HALTED));
  assign operand = ir[ADDR_W-1:0];
  assign rd_opc  = 4'(rd_data[DATA_W-1:ADDR_W]);
  assign ir_opc  = 4'(ir[DATA_W-1:ADDR_W]);

  prog_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_prog_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cp_q     <= 1'b0;
      armed    <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      addr_q   <= '0;
      ir       <= '0;
      op_valid <= 1'b0;
      acc_ld   <= 1'b0;
      alu_en   <= 1'b0;
      alu_sub  <= 1'b0;
      out_ld   <= 1'b0;
    end else begin
      cp_q <= cp;
      if (!cp) armed <= 1'b1;

      op_valid <= 1'b0;
      acc_ld   <= 1'b0;
      alu_en   <= 1'b0;
      alu_sub  <= 1'b0;
      out_ld   <= 1'b0;

      // Only one request can wait behind the current instruction; a second is lost.
      if (busy && req) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (req || pending) begin
            state   <= ST_FETCH;
            addr_q  <= pc;
            pending <= pending & req;
          end
        end
        ST_FETCH:   state <= ST_LOAD_IR;
        ST_LOAD_IR: begin
          ir       <= rd_data;
          op_valid <= 1'b1;
          {acc_ld, alu_en, alu_sub, out_ld} <= decode_op(rd_opc);
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ir_opc == OP_HLT) state <= ST_HALTED;
          else                  state <= ST_IDLE;
        end
        ST_HALTED:  state <= ST_HALTED;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed scenarios plus randomized
// traffic, compared every cycle against a job-timeline reference model.
module tb_instr_fetch_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cp = 1'b0;
  logic [3:0] pc = 4'h0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'h0;
  logic [7:0] prog_data = 8'h00;
  logic [7:0] ir;
  logic [3:0] operand;
  logic       op_valid, acc_ld, alu_en, alu_sub, out_ld, busy, halted, overrun;

  logic rst_drive = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference model: each job is a start edge plus address; everything else is
  // timed relative to that start edge.
  int         edge_k = 0;
  bit         m_active, m_pend, m_ovr, m_halted, m_cp_prev, m_seen_low;
  int         job_s;
  logic [3:0] job_addr;
  logic [7:0] job_instr;
  logic [7:0] m_ir;
  logic [7:0] m_mem [16];
  bit         exp_busy, exp_opv;
  int         pulses_seen = 0;
  int         pulses_exp = 0;

  instr_fetch_decode #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .cp        (cp),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ir        (ir),
    .operand   (operand),
    .op_valid  (op_valid),
    .acc_ld    (acc_ld),
    .alu_en    (alu_en),
    .alu_sub   (alu_sub),
    .out_ld    (out_ld),
    .busy      (busy),
    .halted    (halted),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // {acc_ld, alu_en, alu_sub, out_ld} straight from the opcode table
  function automatic logic [3:0] exp_strobes(input logic [7:0] instr);
    case (instr[7:4])
      4'h0:    return 4'b1000;
      4'h1:    return 4'b1100;
      4'h2:    return 4'b1110;
      4'hE:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_pend     = 1'b0;
    m_ovr      = 1'b0;
    m_halted   = 1'b0;
    m_cp_prev  = 1'b0;
    m_seen_low = 1'b0;
    m_ir       = 8'h00;
    exp_busy   = 1'b0;
    exp_opv    = 1'b0;
  endtask

  task automatic model_edge();
    int k;
    bit busy_before, idle_before, halted_before, req;
    k = edge_k;
    edge_k++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    halted_before = m_halted;
    busy_before   = m_active && !m_halted && (k <= job_s + 3);
    idle_before   = !halted_before && !busy_before;
    req           = cp && !m_cp_prev && m_seen_low;
    if (m_active && k == job_s + 1) job_instr = m_mem[job_addr];
    if (m_active && k == job_s + 2) m_ir = job_instr;
    if (m_active && k == job_s + 3 && job_instr[7:4] == 4'hF) m_halted = 1'b1;
    if (idle_before) begin
      if (req || m_pend) begin
        m_active = 1'b1;
        job_s    = k;
        job_addr = pc;
        m_pend   = m_pend && req;
      end
    end else if (busy_before && req) begin
      if (m_pend) m_ovr = 1'b1;
      else        m_pend = 1'b1;
    end
    if (prog_we && (halted_before || idle_before)) m_mem[prog_addr] = prog_data;
    m_seen_low = m_seen_low || !cp;
    m_cp_prev  = cp;
    exp_busy   = m_active && !m_halted && (k - job_s <= 2);
    exp_opv    = m_active && (k == job_s + 2);
    if (exp_opv) pulses_exp++;
  endtask

  task automatic compare_all();
    checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
    checkOutput("halted", {31'd0, halted}, {31'd0, m_halted});
    checkOutput("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    checkOutput("op_valid", {31'd0, op_valid}, {31'd0, exp_opv});
    checkOutput("ir", {24'd0, ir}, {24'd0, m_ir});
    checkOutput("operand", {28'd0, operand}, {28'd0, m_ir[3:0]});
    checkOutput("strobes", {28'd0, acc_ld, alu_en, alu_sub, out_ld},
                {28'd0, (exp_opv ? exp_strobes(m_ir) : 4'b0000)});
    if (op_valid === 1'b1) pulses_seen++;
  endtask

  task automatic applyStimulus(input logic c, input logic [3:0] p, input logic we,
                               input logic [3:0] wa, input logic [7:0] wd);
    @(negedge clk);
    rst_n     = rst_drive;
    cp        = c;
    pc        = p;
    prog_we   = we;
    prog_addr = wa;
    prog_data = wd;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, pc, 1'b0, 4'h0, 8'h00);
  endtask

  // Asserts rst_n mid-cycle, checks the immediate effect, holds across one edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    checkOutput("async_ir", {24'd0, ir}, 32'd0);
    checkOutput("async_busy", {31'd0, busy}, 32'd0);
    rst_drive = 1'b0;
    applyStimulus(cp, pc, 1'b0, 4'h0, 8'h00);
    rst_drive = 1'b1;
  endtask

  initial begin
    logic [7:0] val;
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
    rst_drive = 1'b1;

    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       val = 8'hE0;
        3:       val = 8'h1A;
        5:       val = 8'hF0;
        7:       val = 8'h15;
        15:      val = 8'h2C;
        default: val = {4'(i % 3), 4'(i)};
      endcase
      applyStimulus(1'b0, 4'h0, 1'b1, 4'(i), val);
    end
    idle(2);

    $display("[TB] ADD from mem[3]");
    applyStimulus(1'b1, 4'h3, 1'b0, 4'h0, 8'h00);
    idle(2);
    checkOutput("t1_opv", {31'd0, op_valid}, 32'd1);
    checkOutput("t1_ir", {24'd0, ir}, 32'h1A);
    checkOutput("t1_operand", {28'd0, operand}, 32'hA);
    checkOutput("t1_ctl", {28'd0, acc_ld, alu_en, alu_sub, out_ld}, 32'b1100);
    idle(3);

    $display("[TB] SUB at pc=15 then OUT at pc=0");
    applyStimulus(1'b1, 4'hF, 1'b0, 4'h0, 8'h00);
    idle(2);
    checkOutput("t2_sub", {28'd0, acc_ld, alu_en, alu_sub, out_ld}, 32'b1110);
    idle(2);
    applyStimulus(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    idle(2);
    checkOutput("t2_out", {28'd0, acc_ld, alu_en, alu_sub, out_ld}, 32'b0001);
    idle(3);

    $display("[TB] write during fetch is ignored");
    applyStimulus(1'b1, 4'h7, 1'b0, 4'h0, 8'h00);
    applyStimulus(1'b0, 4'h7, 1'b1, 4'h7, 8'h3B);
    applyStimulus(1'b0, 4'h7, 1'b0, 4'h0, 8'h00);
    checkOutput("t3_ir", {24'd0, ir}, 32'h15);
    idle(3);
    applyStimulus(1'b1, 4'h7, 1'b0, 4'h0, 8'h00);
    idle(2);
    checkOutput("t3_refetch", {24'd0, ir}, 32'h15);
    idle(3);

    $display("[TB] back-to-back cp edges");
    pulses_seen = 0;
    pulses_exp  = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'(i + 1), 1'b0, 4'h0, 8'h00);
      applyStimulus(1'b0, 4'(i + 1), 1'b0, 4'h0, 8'h00);
    end
    idle(12);
    checkOutput("t4_overrun", {31'd0, overrun}, 32'd1);
    checkOutput("t4_pulses", pulses_seen, pulses_exp);

    $display("[TB] reset during LOAD_IR");
    async_reset();
    idle(2);
    applyStimulus(1'b1, 4'h3, 1'b0, 4'h0, 8'h00);
    applyStimulus(1'b0, 4'h3, 1'b0, 4'h0, 8'h00);
    pulses_seen = 0;
    async_reset();
    idle(6);
    checkOutput("t5_no_pulse", pulses_seen, 32'd0);

    $display("[TB] HLT at mem[5]");
    applyStimulus(1'b1, 4'h5, 1'b0, 4'h0, 8'h00);
    idle(4);
    checkOutput("t6_halted", {31'd0, halted}, 32'd1);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    pulses_seen = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'h3, 1'b0, 4'h0, 8'h00);
      applyStimulus(1'b0, 4'h3, 1'b0, 4'h0, 8'h00);
    end
    checkOutput("t6_no_pulse", pulses_seen, 32'd0);
    async_reset();
    idle(2);

    $display("[TB] random traffic");
    for (int n = 0; n < 900; n++) begin
      logic we;
      we = ($urandom_range(0, 7) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), we,
                    4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      if (n % 120 == 119) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
